// File: rtl/mem_io_bridge.sv
// mem_io_bridge: address decode, RAM, LEDR/HEX/SW I/O and registered DIN; optional interval timer under TIMER_EN
module mem_io_bridge #(
    parameter int RAM_AW = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    input  logic [9:0]  SW,
    output logic [15:0] DIN,
    output logic [9:0]  LEDR,
    output logic [41:0] HEX
);
    logic [3:0]  region;
    logic [2:0]  dig;
    logic        hex_ok;
    logic [15:0] ram [2**RAM_AW];
    logic [15:0] ram_q;
    logic [9:0]  sw_meta, sw_sync;
    logic [15:0] timer_rd;
    logic [15:0] rd;
    logic        unused_addr;

    assign region = ADDR[15:12];
    assign dig = ADDR[2:0];
    assign hex_ok = dig < 3'd6;
    assign ram_q = ram[ADDR[RAM_AW-1:0]];
    assign unused_addr = ^ADDR[11:3];

    always_ff @(posedge Clock)
        if (Resetn && W && region == 4'h0)
            ram[ADDR[RAM_AW-1:0]] <= DOUT;

    always_ff @(posedge Clock)
        if (!Resetn) begin
            LEDR <= '0;
            HEX <= '1;
        end else if (W) begin
            if (region == 4'h1)
                LEDR <= DOUT[9:0];
            if (region == 4'h2 && hex_ok)
                HEX[7*int'(dig) +: 7] <= DOUT[6:0];
        end

    always_ff @(posedge Clock)
        if (!Resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end

`ifdef TIMER_EN
    logic        t_en, t_flag, t_zero, wr_ctrl, wr_reload;
    logic [15:0] t_reload, t_count;

    assign t_zero = t_count == 16'h0;
    assign wr_ctrl = W && ADDR == 16'h4000;
    assign wr_reload = W && ADDR == 16'h4001;
    assign timer_rd = ADDR == 16'h4000 ? {14'b0, t_flag, t_en} :
                      ADDR == 16'h4001 ? t_reload : 16'h0;

    // reload write overrides the running count; a same-cycle flag set beats a clear
    always_ff @(posedge Clock)
        if (!Resetn) begin
            t_en <= 1'b0;
            t_flag <= 1'b0;
            t_reload <= '0;
            t_count <= '0;
        end else begin
            if (t_en)
                t_count <= t_zero ? t_reload : t_count - 16'd1;
            if (wr_reload) begin
                t_reload <= DOUT;
                t_count <= DOUT;
            end
            if (wr_ctrl)
                t_en <= DOUT[0];
            if (t_en && t_zero)
                t_flag <= 1'b1;
            else if (wr_ctrl && DOUT[1])
                t_flag <= 1'b0;
        end
`else
    assign timer_rd = 16'h0;
`endif

    always_comb
        rd = region == 4'h0 ? ram_q :
             region == 4'h1 ? {6'b0, LEDR} :
             region == 4'h2 ? (hex_ok ? {9'b0, HEX[7*int'(dig) +: 7]} : 16'h0) :
             region == 4'h3 ? {6'b0, sw_sync} :
             region == 4'h4 ? timer_rd : 16'h0;

    always_ff @(posedge Clock)
        DIN <= Resetn ? rd : 16'h0;
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed vectors with hand-computed expectations for mem_io_bridge
module tb_mem_io_bridge;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] ADDR, DOUT, DIN;
    logic        W;
    logic [9:0]  SW, LEDR;
    logic [41:0] HEX, hex_exp;
    int          total = 0;
    int          bad = 0;

    mem_io_bridge #(.RAM_AW(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .SW(SW), .DIN(DIN), .LEDR(LEDR), .HEX(HEX)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        Resetn = 1'b0; W = 1'b0; ADDR = 16'h0; DOUT = 16'h0; SW = 10'h0;
        tick(); tick();
        chk("rst_din", DIN, 16'h0);
        chk("rst_ledr", LEDR, 10'h0);
        chk("rst_hex", HEX, 42'h3FF_FFFF_FFFF);
        Resetn = 1'b1; ADDR = 16'h4000;
        tick();
        chk("rst_timer", DIN, 16'h0);

        W = 1'b1; ADDR = 16'h0005; DOUT = 16'hBEEF; tick();
        W = 1'b0; tick();
        chk("ram_rd", DIN, 16'hBEEF);
        ADDR = 16'h0105; tick();
        chk("ram_alias", DIN, 16'hBEEF);

        W = 1'b1; ADDR = 16'h1000; DOUT = 16'h03FF; tick();
        W = 1'b0;
        chk("ledr_wr", LEDR, 10'h3FF);
        tick();
        chk("ledr_rd", DIN, 16'h03FF);

        hex_exp = '1;
        hex_exp[27:21] = 7'h40;
        W = 1'b1; ADDR = 16'h2003; DOUT = 16'h0040; tick();
        chk("hex_wr3", HEX, hex_exp);
        ADDR = 16'h2006; DOUT = 16'h0000; tick();
        chk("hex_wr6", HEX, hex_exp);
        W = 1'b0; tick();
        chk("hex_rd6", DIN, 16'h0);
        ADDR = 16'h2003; tick();
        chk("hex_rd3", DIN, 16'h0040);
        ADDR = 16'h2000; tick();
        chk("hex_rd0", DIN, 16'h007F);

        ADDR = 16'h3000; tick(); tick(); tick();
        chk("sw_idle", DIN, 16'h0);
        SW = 10'h2A5; tick();
        chk("sw_c1", DIN, 16'h0);
        tick();
        chk("sw_c2", DIN, 16'h0);
        tick();
        chk("sw_c3", DIN, 16'h02A5);
        W = 1'b1; DOUT = 16'h0000; tick();
        W = 1'b0; tick();
        chk("sw_nowr", DIN, 16'h02A5);
        W = 1'b1; ADDR = 16'h7000; DOUT = 16'hFFFF; tick();
        W = 1'b0;
        chk("unmapped", DIN, 16'h0);

        W = 1'b1; ADDR = 16'h0003; DOUT = 16'h1111; tick();
        DOUT = 16'h2222; tick();
        chk("rdfirst_old", DIN, 16'h1111);
        W = 1'b0; tick();
        chk("rdfirst_new", DIN, 16'h2222);

        Resetn = 1'b0; W = 1'b1; ADDR = 16'h1000; DOUT = 16'h0155; tick();
        chk("mid_rst_ledr", LEDR, 10'h0);
        chk("mid_rst_din", DIN, 16'h0);
        chk("mid_rst_hex", HEX, 42'h3FF_FFFF_FFFF);
        ADDR = 16'h0005; DOUT = 16'h0000; tick();
        Resetn = 1'b1; W = 1'b0; tick();
        chk("rst_ram_nowr", DIN, 16'hBEEF);
        ADDR = 16'h3000; tick();
        chk("rst_sw", DIN, 16'h0);

`ifdef TIMER_EN
        begin
            logic [15:0] texp [1:14] = '{16'h1, 16'h1, 16'h1, 16'h1, 16'h3, 16'h3, 16'h1,
                                         16'h1, 16'h3, 16'h3, 16'h1, 16'h1, 16'h3, 16'h3};
            W = 1'b1; ADDR = 16'h4001; DOUT = 16'h0003; tick();
            ADDR = 16'h4000; DOUT = 16'h0001; tick();
            for (int i = 1; i <= 14; i++) begin
                W = (i == 6 || i == 10 || i == 12);
                DOUT = 16'h0003;
                tick();
                chk($sformatf("timer_e%0d", i), DIN, texp[i]);
            end
            W = 1'b0; ADDR = 16'h4001; tick();
            chk("timer_reload_rd", DIN, 16'h0003);
            Resetn = 1'b0; ADDR = 16'h4000; tick();
            Resetn = 1'b1; tick();
            chk("timer_rst_ctrl", DIN, 16'h0);
            ADDR = 16'h4001; tick();
            chk("timer_rst_reload", DIN, 16'h0);
        end
`else
        W = 1'b1; ADDR = 16'h4000; DOUT = 16'h0001; tick();
        W = 1'b0; tick(); tick();
        chk("no_timer", DIN, 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
